// File: rtl/game_timer_if.sv
// Game timer signal bundle.
//   GameActive  : game FSM -> timer, high while a game is in progress
//   TimerDone   : timer -> game FSM, expiry pulse
//   SecondTick  : timer -> display path, one-cycle pulse per decrement
//   SecondsLeft : timer -> display path, remaining seconds (binary)
//   SecondsTens : timer -> display path, BCD tens digit
//   SecondsOnes : timer -> display path, BCD ones digit
// master = game FSM / display side, slave = the timer itself.
interface game_timer_if;
  logic       GameActive;
  logic       TimerDone;
  logic       SecondTick;
  logic [6:0] SecondsLeft;
  logic [3:0] SecondsTens;
  logic [3:0] SecondsOnes;

  modport master (
    output GameActive,
    input  TimerDone,
    input  SecondTick,
    input  SecondsLeft,
    input  SecondsTens,
    input  SecondsOnes
  );

  modport slave (
    input  GameActive,
    output TimerDone,
    output SecondTick,
    output SecondsLeft,
    output SecondsTens,
    output SecondsOnes
  );
endinterface

// File: rtl/game_timer.sv
// Countdown timer feeding the game-state FSM. Counts GAME_SECONDS down while
// GameActive is high, pulses TimerDone for DONE_CYCLES cycles on expiry, then
// waits for GameActive to drop before re-arming. Seconds-left is kept both in
// binary and as a parallel BCD counter for the HEX display path.
// Ports:
//   Clock  : system clock, all updates on posedge
//   Resetn : asynchronous active-low reset
//   bus    : game_timer_if.slave (GameActive in; TimerDone, SecondTick,
//            SecondsLeft, SecondsTens, SecondsOnes out; all registered)
module game_timer #(
  parameter int unsigned CLOCK_HZ     = 50000000,
  parameter int unsigned GAME_SECONDS = 60,
  parameter int unsigned DONE_CYCLES  = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  game_timer_if.slave  bus
);

  localparam int unsigned PRE_W  = (CLOCK_HZ > 1) ? $clog2(CLOCK_HZ) : 1;
  localparam int unsigned DONE_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLOCK_HZ - 1);
  localparam logic [DONE_W-1:0] DONE_LAST = DONE_W'(DONE_CYCLES - 1);
  localparam logic [6:0]        SEC_INIT  = 7'(GAME_SECONDS);
  localparam logic [3:0]        TENS_INIT = 4'(GAME_SECONDS / 10);
  localparam logic [3:0]        ONES_INIT = 4'(GAME_SECONDS % 10);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    EXPIRED  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t              state;
  logic [PRE_W-1:0]    prescaler;
  logic [DONE_W-1:0]   done_cnt;
  logic                timer_done;
  logic                second_tick;
  logic [6:0]          seconds_left;
  logic [3:0]          seconds_tens;
  logic [3:0]          seconds_ones;

  // Timer FSM with all outputs registered; GameActive only affects next state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state        <= IDLE;
      prescaler    <= '0;
      done_cnt     <= '0;
      timer_done   <= 1'b0;
      second_tick  <= 1'b0;
      seconds_left <= SEC_INIT;
      seconds_tens <= TENS_INIT;
      seconds_ones <= ONES_INIT;
    end else begin
      second_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          prescaler    <= '0;
          done_cnt     <= '0;
          timer_done   <= 1'b0;
          seconds_left <= SEC_INIT;
          seconds_tens <= TENS_INIT;
          seconds_ones <= ONES_INIT;
          if (bus.GameActive) state <= RUNNING;
        end

        RUNNING: begin
          if (!bus.GameActive) begin
            // Abort beats a coincident tick: reload, no decrement shown.
            state        <= IDLE;
            prescaler    <= '0;
            seconds_left <= SEC_INIT;
            seconds_tens <= TENS_INIT;
            seconds_ones <= ONES_INIT;
          end else if (prescaler == PRE_LAST) begin
            prescaler   <= '0;
            second_tick <= 1'b1;
            if (seconds_left == 7'd1) begin
              seconds_left <= 7'd0;
              seconds_tens <= 4'd0;
              seconds_ones <= 4'd0;
              timer_done   <= 1'b1;
              done_cnt     <= '0;
              state        <= EXPIRED;
            end else begin
              seconds_left <= seconds_left - 7'd1;
              // Parallel BCD decrement: ones borrows from tens on 0 -> 9.
              if (seconds_ones == 4'd0) begin
                seconds_ones <= 4'd9;
                seconds_tens <= seconds_tens - 4'd1;
              end else begin
                seconds_ones <= seconds_ones - 4'd1;
              end
            end
          end else begin
            prescaler <= prescaler + PRE_W'(1);
          end
        end

        EXPIRED: begin
          // Pulse always runs its full length, GameActive is ignored here.
          if (done_cnt == DONE_LAST) begin
            timer_done <= 1'b0;
            state      <= COOLDOWN;
          end else begin
            done_cnt <= done_cnt + DONE_W'(1);
          end
        end

        COOLDOWN: begin
          // Re-arm only after the game has visibly left the active state.
          if (!bus.GameActive) begin
            state        <= IDLE;
            prescaler    <= '0;
            seconds_left <= SEC_INIT;
            seconds_tens <= TENS_INIT;
            seconds_ones <= ONES_INIT;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.TimerDone   = timer_done;
  assign bus.SecondTick  = second_tick;
  assign bus.SecondsLeft = seconds_left;
  assign bus.SecondsTens = seconds_tens;
  assign bus.SecondsOnes = seconds_ones;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer: table-driven vectors with a scoreboard
// queue, plus hand-written sequences for reset, BCD stepping and the loop
// closed through a small game-FSM model.
module tb_game_timer;

  logic clk = 1'b0;
  logic rst_n;
  logic start_game;
  logic [1:0] gstate;

  always #5 clk = ~clk;

  game_timer_if bus_a ();
  game_timer_if bus_b ();
  game_timer_if bus_c ();

  game_timer #(.CLOCK_HZ(10), .GAME_SECONDS(3), .DONE_CYCLES(4)) dut_a (
    .Clock(clk), .Resetn(rst_n), .bus(bus_a.slave));
  game_timer #(.CLOCK_HZ(10), .GAME_SECONDS(21), .DONE_CYCLES(4)) dut_b (
    .Clock(clk), .Resetn(rst_n), .bus(bus_b.slave));
  game_timer #(.CLOCK_HZ(10), .GAME_SECONDS(3), .DONE_CYCLES(4)) dut_c (
    .Clock(clk), .Resetn(rst_n), .bus(bus_c.slave));

  // Game FSM model: 0 = done, 1 = playing, 2 = waiting for TimerDone to fall.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gstate <= 2'd0;
    else begin
      case (gstate)
        2'd0:    if (start_game) gstate <= 2'd1;
        2'd1:    if (bus_c.TimerDone) gstate <= 2'd2;
        2'd2:    if (!bus_c.TimerDone) gstate <= 2'd0;
        default: gstate <= 2'd0;
      endcase
    end
  end
  assign bus_c.GameActive = (gstate != 2'd0);

  typedef struct packed {
    logic       done;
    logic       tick;
    logic [6:0] sec;
    logic [3:0] tens;
    logic [3:0] ones;
  } obs_t;

  typedef struct {
    logic ga;
    int   cycles;
    int   sec;
    logic done;
    logic tick;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[20];
  int   passed = 0;
  int   total  = 0;

  function automatic obs_t mk(int sec, logic done, logic tick);
    obs_t o;
    o.done = done;
    o.tick = tick;
    o.sec  = 7'(sec);
    o.tens = 4'(sec / 10);
    o.ones = 4'(sec % 10);
    return o;
  endfunction

  function automatic obs_t obs_a();
    return {bus_a.TimerDone, bus_a.SecondTick, bus_a.SecondsLeft, bus_a.SecondsTens, bus_a.SecondsOnes};
  endfunction
  function automatic obs_t obs_b();
    return {bus_b.TimerDone, bus_b.SecondTick, bus_b.SecondsLeft, bus_b.SecondsTens, bus_b.SecondsOnes};
  endfunction
  function automatic obs_t obs_c();
    return {bus_c.TimerDone, bus_c.SecondTick, bus_c.SecondsLeft, bus_c.SecondsTens, bus_c.SecondsOnes};
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got done=%0b tick=%0b sec=%0d bcd=%0d,%0d expected done=%0b tick=%0b sec=%0d bcd=%0d,%0d",
                  name, got.done, got.tick, got.sec, got.tens, got.ones,
                  exp.done, exp.tick, exp.sec, exp.tens, exp.ones);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Drive one vector; expected outputs pushed on drive, popped after the edge.
  task automatic run_vec(input int idx);
    obs_t e;
    for (int c = 0; c < vecs[idx].cycles; c++) begin
      bus_a.GameActive = vecs[idx].ga;
      sb.push_back(mk(vecs[idx].sec, vecs[idx].done, vecs[idx].tick));
      @(negedge clk);
      e = sb.pop_front();
      check_obs($sformatf("vec%0d_cyc%0d", idx, c), obs_a(), e);
    end
  endtask

  // One game on dut_c via StartGame; returns cycles to TimerDone and ticks seen.
  task automatic play_c(output int n, output int ticks);
    n = 0;
    ticks = 0;
    start_game = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start_game = 1'b0;
      if (bus_c.SecondTick) ticks++;
    end while (!bus_c.TimerDone && n < 80);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks, len;

    //          ga    cyc sec done  tick
    vecs[0]  = '{1'b1, 10, 3, 1'b0, 1'b0};  // running, first second
    vecs[1]  = '{1'b1,  1, 2, 1'b0, 1'b1};  // tick 10 cycles after entry
    vecs[2]  = '{1'b1,  9, 2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1,  1, 1, 1'b0, 1'b1};
    vecs[4]  = '{1'b1,  9, 1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1,  1, 0, 1'b1, 1'b1};  // final tick raises TimerDone
    vecs[6]  = '{1'b1,  3, 0, 1'b1, 1'b0};  // pulse 4 cycles total
    vecs[7]  = '{1'b1,  1, 0, 1'b0, 1'b0};  // pulse ends with GameActive still 1
    vecs[8]  = '{1'b1, 50, 0, 1'b0, 1'b0};  // cooldown, no restart
    vecs[9]  = '{1'b0,  1, 3, 1'b0, 1'b0};  // drop -> reload one edge later
    vecs[10] = '{1'b0,  5, 3, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 10, 3, 1'b0, 1'b0};  // abort game
    vecs[12] = '{1'b1,  1, 2, 1'b0, 1'b1};
    vecs[13] = '{1'b1,  4, 2, 1'b0, 1'b0};
    vecs[14] = '{1'b0,  1, 3, 1'b0, 1'b0};  // abort reloads, no TimerDone
    vecs[15] = '{1'b1, 10, 3, 1'b0, 1'b0};  // restart: fresh 10-cycle first tick
    vecs[16] = '{1'b1,  1, 2, 1'b0, 1'b1};
    vecs[17] = '{1'b0,  1, 3, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 10, 3, 1'b0, 1'b0};
    vecs[19] = '{1'b0,  1, 3, 1'b0, 1'b0};  // abort on tick cycle wins

    rst_n = 1'b0;
    start_game = 1'b0;
    bus_a.GameActive = 1'b0;
    bus_b.GameActive = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_obs("reset_a", obs_a(), mk(3, 1'b0, 1'b0));
    check_obs("reset_b", obs_b(), mk(21, 1'b0, 1'b0));

    for (int i = 0; i < 20; i++) run_vec(i);

    // Asynchronous reset mid-run: values change without a clock edge.
    bus_a.GameActive = 1'b1;
    repeat (15) @(negedge clk);
    check_obs("pre_reset_run", obs_a(), mk(2, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 check_obs("async_reset_run", obs_a(), mk(3, 1'b0, 1'b0));
    bus_a.GameActive = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-pulse: TimerDone drops at once.
    bus_a.GameActive = 1'b1;
    repeat (32) @(negedge clk);
    check_obs("pre_reset_pulse", obs_a(), mk(0, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1 check_obs("async_reset_pulse", obs_a(), mk(3, 1'b0, 1'b0));
    bus_a.GameActive = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_obs("idle_after_reset", obs_a(), mk(3, 1'b0, 1'b0));

    // BCD stepping over a 21-second game, including the 10 -> 9 borrow.
    bus_b.GameActive = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus_b.SecondTick && n < 15);
      check_int($sformatf("bcd_period_%0d", i), n, (i == 1) ? 11 : 10);
      check_obs($sformatf("bcd_tick_%0d", i), obs_b(), mk(21 - i, (i == 21), 1'b1));
    end
    bus_b.GameActive = 1'b0;

    // Interlock with game FSM model: two back-to-back games.
    for (int g = 0; g < 2; g++) begin
      play_c(n, ticks);
      check_int($sformatf("c%0d_latency", g), n, 32);
      check_int($sformatf("c%0d_ticks", g), ticks, 3);
      len = 1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (bus_c.TimerDone) len++;
      end while (bus_c.TimerDone && n < 20);
      check_int($sformatf("c%0d_done_len", g), len, 4);
      n = 0;
      while (gstate != 2'd0 && n < 5) begin
        @(negedge clk);
        n++;
      end
      check_int($sformatf("c%0d_state_done", g), int'(gstate), 0);
      repeat (2) @(negedge clk);
      check_obs($sformatf("c%0d_reloaded", g), obs_c(), mk(3, 1'b0, 1'b0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
